// File: rtl/board_pkg.sv
// Shared M90 board definitions: interrupt source indices, controller state
// encoding and vector helpers.
package board_pkg;

   localparam int IRQ_VBLANK = 0;
   localparam int IRQ_HINT   = 1;
   localparam int IRQ_SOUND  = 2;
   localparam int IRQ_SPARE  = 3;

   // Offset of the spurious vector, returned when an ack finds nothing eligible
   localparam logic [7:0] IRQ_SPUR_OFS = 8'h1C;

   typedef enum logic {IRQ_IDLE, IRQ_ACK} irq_state_t;

   function automatic logic [7:0] irq_vec(input logic [7:0] base, input logic [1:0] idx);
      return base + {4'd0, idx, 2'b00};
   endfunction

   function automatic logic [3:0] irq_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/irq_prio4.sv
// Four-input priority encoder: reports the lowest-index set bit and whether
// any bit is set.
module irq_prio4
   import board_pkg::*;
(
   input  logic [3:0] req,
   output logic [1:0] idx,
   output logic       vld
);

   always_comb begin
      idx = 2'd0;
      vld = |req;
      for (int i = IRQ_SPARE; i >= IRQ_VBLANK; i--) begin
         if (req[i]) idx = 2'(i);
      end
   end

endmodule

// File: rtl/m90_irq_ctrl.sv
// M90 interrupt controller: edge-triggered pending latch, software mask,
// fixed priority with in-service blocking, and INTAK vector delivery to the V33.
module m90_irq_ctrl
   import board_pkg::*;
#(
   parameter logic [7:0] VEC_BASE = 8'h60,
   parameter logic [7:0] IO_BASE  = 8'h40
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       ce,
   input  logic [3:0] src,
   input  logic       intack,
   input  logic       io_wr,
   input  logic [7:0] io_addr,
   input  logic [7:0] io_din,
   output logic       int_req,
   output logic [7:0] int_vector,
   output logic [3:0] pending
);

   localparam logic [7:0] EOI_ADDR = IO_BASE + 8'd2;

   irq_state_t state;
   logic [3:0] src_d;
   logic       intack_d;
   logic [3:0] mask;
   logic [3:0] in_service;
   logic [1:0] sel;
   logic       sel_vld;

   logic [3:0] trig;
   logic [3:0] unblk;
   logic [3:0] cand;
   logic [1:0] is_idx;
   logic       is_vld;
   logic [1:0] win_idx;
   logic       win_vld;
   logic       ack_done;
   logic [3:0] ack_bit;
   logic [3:0] eoi_bit;
   logic       unused_din;

   assign unused_din = ^io_din[7:4];

   assign trig = src & ~src_d;

   irq_prio4 u_is_prio (
      .req (in_service),
      .idx (is_idx),
      .vld (is_vld)
   );

   // Any in-service source blocks itself and every lower-priority source
   always_comb begin
      unblk = 4'hF;
      if (is_vld) begin
         case (is_idx)
            2'd0:    unblk = 4'b0000;
            2'd1:    unblk = 4'b0001;
            2'd2:    unblk = 4'b0011;
            default: unblk = 4'b0111;
         endcase
      end
   end

   assign cand = pending & ~mask & unblk;

   irq_prio4 u_win_prio (
      .req (cand),
      .idx (win_idx),
      .vld (win_vld)
   );

   assign ack_done = (state == IRQ_ACK) && !intack;
   assign ack_bit  = (ack_done && sel_vld) ? irq_onehot(sel) : 4'b0000;
   assign eoi_bit  = (io_wr && io_addr == EOI_ADDR) ? irq_onehot(io_din[1:0]) : 4'b0000;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IRQ_IDLE;
         src_d      <= 4'b0000;
         intack_d   <= 1'b0;
         mask       <= 4'hF;
         pending    <= 4'b0000;
         in_service <= 4'b0000;
         sel        <= 2'd0;
         sel_vld    <= 1'b0;
         int_req    <= 1'b0;
         int_vector <= VEC_BASE;
      end else if (ce) begin
         src_d      <= src;
         intack_d   <= intack;
         // A new edge on the source being retired re-arms it
         pending    <= (pending & ~ack_bit) | trig;
         in_service <= (in_service & ~eoi_bit) | ack_bit;
         if (io_wr && io_addr == IO_BASE) mask <= io_din[3:0];

         case (state)
            IRQ_IDLE: begin
               if (intack && !intack_d) begin
                  state      <= IRQ_ACK;
                  int_req    <= 1'b0;
                  sel        <= win_idx;
                  sel_vld    <= win_vld;
                  int_vector <= win_vld ? irq_vec(VEC_BASE, win_idx)
                                        : VEC_BASE + IRQ_SPUR_OFS;
               end else begin
                  int_req <= win_vld;
               end
            end
            IRQ_ACK: begin
               int_req <= 1'b0;
               if (!intack) state <= IRQ_IDLE;
            end
            default: state <= IRQ_IDLE;
         endcase
      end
   end

endmodule
